// File: rtl/n8_responder.sv
// n8_responder: controller end of the N8 serial button protocol.
// The host drives latch/pulse; the buttons are returned serially on data_out (active-low).
// Optional turbo on A/B is compiled in with `define N8_RESPONDER_TURBO_EN.
module n8_responder #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TURBO_LATCHES = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       latch,
  input  logic       pulse,
  input  logic       a,
  input  logic       b,
  input  logic       select,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       turbo_a,
  input  logic       turbo_b,
  output logic       data_out,
  output logic       frame_strobe,
  output logic [3:0] bit_count,
  output logic       overread
);

  localparam int unsigned SW = SYNC_STAGES;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 4;

  logic [SW-1:0] latch_sync_q, latch_sync_d;
  logic [SW-1:0] pulse_sync_q, pulse_sync_d;
  logic          latch_hist_q, latch_hist_d;
  logic          pulse_hist_q, pulse_hist_d;
  logic [BW-1:0] sr_q, sr_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic          data_out_q, data_out_d;
  logic          frame_strobe_q, frame_strobe_d;
  logic          overread_q, overread_d;

  logic          latch_s, pulse_s;
  logic          latch_fall, pulse_rise;
  logic          eff_a, eff_b;
  logic [BW-1:0] btn_vec;

  assign latch_s    = latch_sync_q[SW-1];
  assign pulse_s    = pulse_sync_q[SW-1];
  assign latch_fall = ~latch_s & latch_hist_q;
  assign pulse_rise = pulse_s & ~pulse_hist_q;

`ifdef N8_RESPONDER_TURBO_EN
  logic [7:0] turbo_cnt_q, turbo_cnt_d;
  logic       phase_q, phase_d;

  // Turbo phase toggles once every TURBO_LATCHES latch falls.
  always_comb begin
    turbo_cnt_d = turbo_cnt_q;
    phase_d     = phase_q;
    if (latch_fall) begin
      if (turbo_cnt_q + 8'd1 == 8'(TURBO_LATCHES)) begin
        turbo_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + 8'd1;
      end
    end
  end

  // Turbo counter and phase registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      turbo_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      turbo_cnt_q <= turbo_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign eff_a = a | (turbo_a & phase_q);
  assign eff_b = b | (turbo_b & phase_q);
`else
  logic unused_turbo;
  assign unused_turbo = ^{turbo_a, turbo_b};
  assign eff_a        = a;
  assign eff_b        = b;
`endif

  assign btn_vec = {right, left, down, up, start, select, eff_b, eff_a};

  // Synchronizers, edge detection, and the load/shift datapath.
  always_comb begin
    latch_sync_d   = {latch_sync_q[SW-2:0], latch};
    pulse_sync_d   = {pulse_sync_q[SW-2:0], pulse};
    latch_hist_d   = latch_s;
    pulse_hist_d   = pulse_s;
    sr_d           = sr_q;
    bit_count_d    = bit_count_q;
    frame_strobe_d = 1'b0;
    overread_d     = 1'b0;
    if (latch_s) begin
      sr_d        = btn_vec;
      bit_count_d = '0;
    end else if (latch_fall) begin
      frame_strobe_d = 1'b1;
    end else if (pulse_rise) begin
      if (bit_count_q < CW'(BW)) begin
        sr_d        = {1'b0, sr_q[BW-1:1]};
        bit_count_d = bit_count_q + CW'(1);
      end else begin
        overread_d = 1'b1;
      end
    end
    data_out_d = ~sr_d[0];
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q   <= '0;
      pulse_sync_q   <= '0;
      latch_hist_q   <= 1'b0;
      pulse_hist_q   <= 1'b0;
      sr_q           <= '0;
      bit_count_q    <= '0;
      data_out_q     <= 1'b1;
      frame_strobe_q <= 1'b0;
      overread_q     <= 1'b0;
    end else begin
      latch_sync_q   <= latch_sync_d;
      pulse_sync_q   <= pulse_sync_d;
      latch_hist_q   <= latch_hist_d;
      pulse_hist_q   <= pulse_hist_d;
      sr_q           <= sr_d;
      bit_count_q    <= bit_count_d;
      data_out_q     <= data_out_d;
      frame_strobe_q <= frame_strobe_d;
      overread_q     <= overread_d;
    end
  end

  assign data_out     = data_out_q;
  assign frame_strobe = frame_strobe_q;
  assign bit_count    = bit_count_q;
  assign overread     = overread_q;

endmodule

// File: tb/tb_n8_responder.sv
// Bench for n8_responder: emulates an N8 host and scores the serial stream.
module tb_n8_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       latch, pulse;
  logic       a, b, select, start, up, down, left, right;
  logic       turbo_a, turbo_b;
  logic       data_out, frame_strobe, overread;
  logic [3:0] bit_count;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int over_cnt = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  n8_responder #(.SYNC_STAGES(2), .TURBO_LATCHES(2)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .latch(latch), .pulse(pulse),
    .a(a), .b(b), .select(select), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .turbo_a(turbo_a), .turbo_b(turbo_b),
    .data_out(data_out), .frame_strobe(frame_strobe),
    .bit_count(bit_count), .overread(overread)
  );

  // Strobe monitor; tests compare deltas against a snapshot.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_strobe) strobe_cnt++;
      if (overread) over_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [7:0] v);
    {right, left, down, up, start, select, b, a} = v;
  endtask

  task automatic do_pulse();
    pulse = 1'b1; cyc(6);
    pulse = 1'b0; cyc(6);
  endtask

  task automatic do_latch(input int n);
    latch = 1'b1; cyc(n);
    latch = 1'b0; cyc(6);
  endtask

  task automatic test_reset();
    bit bad;
    bad = 0;
    rst_n = 1'b0;
    set_btn(8'hFF);
    turbo_a = 1'b1; turbo_b = 1'b1;
    latch = 1'b0; pulse = 1'b0;
    cyc(1);
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) latch = ~latch;
      if (i % 2 == 0) pulse = ~pulse;
      cyc(1);
      if (frame_strobe !== 1'b0 || overread !== 1'b0) bad = 1;
    end
    checks++;
    if (data_out !== 1'b1) begin errors++; $display("FAIL reset_data_out: got %b want 1", data_out); end
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL reset_strobes: strobe seen=%b want 0", bad); end
    latch = 1'b0; pulse = 1'b0;
    turbo_a = 1'b0; turbo_b = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_full_frame();
    logic [7:0] v;
    int s0, o0;
    bit exp;
    v = 8'b1000_1001;  // A, Start, Right
    set_btn(v);
    for (int i = 0; i < 8; i++) exp_q.push_back(~v[i]);
    exp_q.push_back(1'b1);
    s0 = strobe_cnt; o0 = over_cnt;
    do_latch(12);
    set_btn(~v);  // buttons after the latch must not leak into the frame
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) do_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL frame_bit%0d: data_out=%b want %b", k, data_out, exp); end
      checks++;
      if (bit_count !== 4'(k)) begin errors++; $display("FAIL frame_count%0d: bit_count=%0d want %0d", k, bit_count, k); end
    end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL frame_strobe_count: got %0d want 1", strobe_cnt - s0); end
    checks++;
    if (over_cnt - o0 != 0) begin errors++; $display("FAIL frame_overread_count: got %0d want 0", over_cnt - o0); end
  endtask

  task automatic test_overread();
    int o0;
    bit exp;
    o0 = over_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b1);
      do_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL over_data%0d: data_out=%b want %b", k, data_out, exp); end
      checks++;
      if (bit_count !== 4'd8) begin errors++; $display("FAIL over_count%0d: bit_count=%0d want 8", k, bit_count); end
    end
    checks++;
    if (over_cnt - o0 != 3) begin errors++; $display("FAIL over_pulses: got %0d want 3", over_cnt - o0); end
  endtask

  task automatic test_latch_dominance();
    int s0, o0;
    set_btn(8'h01);
    s0 = strobe_cnt; o0 = over_cnt;
    latch = 1'b1; cyc(6);
    do_pulse(); do_pulse();
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL dom_count: bit_count=%0d want 0", bit_count); end
    checks++;
    if (data_out !== 1'b0) begin errors++; $display("FAIL dom_live_a1: data_out=%b want 0", data_out); end
    a = 1'b0; cyc(3);
    checks++;
    if (data_out !== 1'b1) begin errors++; $display("FAIL dom_live_a0: data_out=%b want 1", data_out); end
    set_btn(8'h01); cyc(4);
    latch = 1'b0; pulse = 1'b1;  // simultaneous latch fall and pulse rise
    cyc(8);
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL same_cycle_count: bit_count=%0d want 0", bit_count); end
    checks++;
    if (data_out !== 1'b0) begin errors++; $display("FAIL same_cycle_data: data_out=%b want 0", data_out); end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL same_cycle_strobe: got %0d want 1", strobe_cnt - s0); end
    checks++;
    if (over_cnt - o0 != 0) begin errors++; $display("FAIL same_cycle_overread: got %0d want 0", over_cnt - o0); end
    pulse = 1'b0; cyc(6);
    do_pulse();
    checks++;
    if (bit_count !== 4'd1) begin errors++; $display("FAIL same_cycle_next_count: bit_count=%0d want 1", bit_count); end
    checks++;
    if (data_out !== 1'b1) begin errors++; $display("FAIL same_cycle_next_data: data_out=%b want 1", data_out); end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] v;
    bit exp;
    int s0;
    set_btn(8'b0101_1010);
    do_latch(8);
    do_pulse(); do_pulse(); do_pulse();
    checks++;
    if (bit_count !== 4'd3) begin errors++; $display("FAIL mid_pre_count: bit_count=%0d want 3", bit_count); end
    rst_n = 1'b0; #2;
    checks++;
    if (data_out !== 1'b1) begin errors++; $display("FAIL mid_rst_data: data_out=%b want 1", data_out); end
    checks++;
    if (bit_count !== 4'd0) begin errors++; $display("FAIL mid_rst_count: bit_count=%0d want 0", bit_count); end
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    v = 8'b1010_0101;
    set_btn(v);
    for (int i = 0; i < 8; i++) exp_q.push_back(~v[i]);
    exp_q.push_back(1'b1);
    s0 = strobe_cnt;
    do_latch(10);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) do_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL mid_frame_bit%0d: data_out=%b want %b", k, data_out, exp); end
    end
    checks++;
    if (bit_count !== 4'd8) begin errors++; $display("FAIL mid_frame_count: bit_count=%0d want 8", bit_count); end
    checks++;
    if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL mid_frame_strobe: got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_turbo();
    bit exp;
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(5);
    set_btn(8'h00);
    turbo_a = 1'b1; turbo_b = 1'b0;
    for (int f = 0; f < 8; f++) begin
`ifdef N8_RESPONDER_TURBO_EN
      exp_q.push_back(((f / 2) % 2) == 0);
`else
      exp_q.push_back(1'b1);
`endif
      do_latch(8);
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin errors++; $display("FAIL turbo_frame%0d: data_out=%b want %b", f, data_out, exp); end
    end
    turbo_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overread();
    test_latch_dominance();
    test_midframe_reset();
    test_turbo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
